// File: rtl/parking_display_driver.sv
// Binary -> BCD (shift-add-3) seven-segment driver with leading-zero blanking,
// out-of-range dash display and a continuously running digit multiplexer.
module parking_display_driver #(
  parameter int BIN_W       = 8,
  parameter int DIGITS      = 3,
  parameter int MAX_VALUE   = 200,
  parameter int REFRESH_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BIN_W-1:0]  value,
  input  logic              valid,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // A limit at or above the input's full scale can never be exceeded.
  localparam bit               NEVER_ERR = (MAX_VALUE >= (2 ** BIN_W) - 1);
  localparam logic [BIN_W-1:0] MAX_V     = NEVER_ERR ? '1 : BIN_W'(MAX_VALUE);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_UPD} state_t;

  state_t                   state_q, state_d;
  logic [BIN_W-1:0]         bin_q, bin_d;
  logic [BCD_W-1:0]         bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     over_q, over_d;
  logic                     err_q, err_d;
  logic                     done_q, done_d;
  logic [DIGITS-1:0][6:0]   disp_q, disp_d, disp_new;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  logic                     lead_zero;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h7E;
      4'd1:    seg_code = 7'h30;
      4'd2:    seg_code = 7'h6D;
      4'd3:    seg_code = 7'h79;
      4'd4:    seg_code = 7'h33;
      4'd5:    seg_code = 7'h5B;
      4'd6:    seg_code = 7'h5F;
      4'd7:    seg_code = 7'h70;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h7B;
      default: seg_code = 7'h01;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
  end

  // Walk from the top digit down; blank zeros until the first nonzero digit.
  always_comb begin
    disp_new  = '0;
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (over_q) begin
        disp_new[i] = 7'h01;
      end else if (lead_zero && (bcd_q[i*4 +: 4] == 4'd0) && (i != 0)) begin
        disp_new[i] = 7'h00;
      end else begin
        disp_new[i] = seg_code(bcd_q[i*4 +: 4]);
        lead_zero   = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    over_d  = over_q;
    disp_d  = disp_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (valid) begin
        bin_d   = value;
        bcd_d   = '0;
        cnt_d   = '0;
        over_d  = !NEVER_ERR && (value > MAX_V);
        state_d = S_CONV;
      end
      S_CONV: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_UPD;
      end
      S_UPD: begin
        disp_d  = disp_new;
        err_d   = over_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan: select from the next index so an/seg and the divider stay aligned.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    an_d  = DIGITS'(1) << idx_d;
    seg_d = disp_q[idx_d];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      over_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= DIGITS'(1);
      seg_q   <= 7'h00;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      over_q  <= over_d;
      err_q   <= err_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign an    = an_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_parking_display_driver.sv
// Scoreboard bench: stimulus pushes hand-computed display expectations, a
// monitor pops one per done pulse and checks err plus every scanned digit.
module tb_parking_display_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = '0;
  logic       valid = 1'b0;
  logic       ready, busy, done, err;
  logic [2:0] an;
  logic [6:0] seg;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic            e;
    logic [2:0][6:0] d;
  } exp_t;
  exp_t sb[$];

  parking_display_driver #(.BIN_W(8), .DIGITS(3), .MAX_VALUE(200), .REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .value(value), .valid(valid), .ready(ready),
    .busy(busy), .done(done), .err(err), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: on each done pulse, pop an expectation and sample one full scan.
  initial begin
    exp_t       e;
    logic [6:0] got [3];
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("err", {31'd0, err}, {31'd0, e.e});
          for (int j = 0; j < 3; j++) got[j] = 'x;
          for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            case (an)
              3'b001:  got[0] = seg;
              3'b010:  got[1] = seg;
              3'b100:  got[2] = seg;
              default: chk("an_onehot", {29'd0, an}, 32'd1);
            endcase
          end
          chk("digit0", {25'd0, got[0]}, {25'd0, e.d[0]});
          chk("digit1", {25'd0, got[1]}, {25'd0, e.d[1]});
          chk("digit2", {25'd0, got[2]}, {25'd0, e.d[2]});
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  task automatic push(input logic e, input logic [6:0] d0, d1, d2);
    exp_t x;
    x.e    = e;
    x.d[0] = d0;
    x.d[1] = d1;
    x.d[2] = d2;
    sb.push_back(x);
  endtask

  task automatic drive(input logic [7:0] v);
    value = v;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_done_settle();
    int t = 0;
    while (done !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1) chk("done_timeout", {31'd0, done}, 32'd1);
    repeat (16) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] v, input logic e, input logic [6:0] d0, d1, d2);
    wait_ready();
    push(e, d0, d1, d2);
    drive(v);
    wait_done_settle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle scan from reset: blank display, an rotates every 4 cycles.
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      chk("idle_an", {29'd0, an}, 32'd1 << ((k / 4) % 3));
      chk("idle_seg", {25'd0, seg}, 32'd0);
      chk("idle_rdy", {30'd0, ready, busy}, 32'b10);
    end

    // 123 with cycle-exact latency check.
    wait_ready();
    push(1'b0, 7'h79, 7'h6D, 7'h30);
    drive(8'd123);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k < 9)       chk("lat_busy", {29'd0, busy, ready, done}, 32'b100);
      else if (k == 9) chk("lat_done", {29'd0, busy, ready, done}, 32'b011);
      else             chk("lat_pulse", {29'd0, busy, ready, done}, 32'b010);
    end
    repeat (16) @(negedge clk);

    send(8'd7,   1'b0, 7'h70, 7'h00, 7'h00);
    send(8'd0,   1'b0, 7'h7E, 7'h00, 7'h00);
    send(8'd250, 1'b1, 7'h01, 7'h01, 7'h01);
    send(8'd200, 1'b0, 7'h7E, 7'h7E, 7'h6D);
    send(8'd201, 1'b1, 7'h01, 7'h01, 7'h01);
    send(8'd100, 1'b0, 7'h7E, 7'h7E, 7'h30);
    send(8'd255, 1'b1, 7'h01, 7'h01, 7'h01);
    send(8'd9,   1'b0, 7'h7B, 7'h00, 7'h00);

    // 45 then 99 held valid through the busy period; 99 must not sneak in.
    wait_ready();
    push(1'b0, 7'h5B, 7'h33, 7'h00);
    drive(8'd45);
    value = 8'd99;
    valid = 1'b1;
    begin
      int t = 0;
      while (done !== 1'b1 && t < 40) begin
        @(negedge clk);
        chk("hold_busy_or_done", {31'd0, busy | done}, 32'd1);
        t++;
      end
      if (done !== 1'b1) chk("done_timeout_45", {31'd0, done}, 32'd1);
    end
    valid = 1'b0;
    repeat (16) @(negedge clk);
    send(8'd99, 1'b0, 7'h7B, 7'h7B, 7'h00);

    // Reset during the conversion of 150 aborts it and blanks the display.
    wait_ready();
    drive(8'd150);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {29'd0, busy, ready, done}, 32'b010);
    chk("rst_an", {29'd0, an}, 32'd1);
    chk("rst_seg", {25'd0, seg}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("rst_nodone", {31'd0, done}, 32'd0);
      chk("rst_blank", {25'd0, seg}, 32'd0);
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
